// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (D/E, E/M, M/W): PC, instruction,
// NUM_CH data channels and T_new, with load / stall-hold / flush and a stall counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned TNEW_W   = 3,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter bit          FLUSH_PC = 1'b1,
    parameter int unsigned SCNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [TNEW_W-1:0]        in_tnew,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [TNEW_W-1:0]        out_tnew,
    output logic [SCNT_W-1:0]        stall_cnt
);

    localparam int unsigned DW = NUM_CH * DATA_W;

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;

    // Hold path never reads in_*, so unknown upstream values cannot leak in during a stall.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        data_d  = data_q;
        tnew_d  = tnew_q;
        scnt_d  = scnt_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = FLUSH_PC ? in_pc : RESET_PC;
            instr_d = '0;
            data_d  = '0;
            tnew_d  = '0;
            scnt_d  = '0;
        end else if (en) begin
            valid_d = in_valid;
            pc_d    = in_pc;
            instr_d = in_instr;
            data_d  = in_data;
            tnew_d  = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
            scnt_d  = '0;
        end else begin
            scnt_d  = (scnt_q == '1) ? scnt_q : scnt_q + SCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            data_q  <= '0;
            tnew_q  <= '0;
            scnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            tnew_q  <= tnew_d;
            scnt_q  <= scnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;
    assign out_data  = data_q;
    assign out_tnew  = tnew_q;
    assign stall_cnt = scnt_q;

endmodule
